// File: rtl/delay_prog.sv
`default_nettype none
// ============================================================================
// Module   : delay_prog
// Brief    : Runtime-programmable delay line (1..MAX_DEL) with valid tracking,
//            clock-enable stall, flush on delay change and refill indication.
// Revision : 1.0 - initial release
// ============================================================================
module delay_prog #(
  parameter int WIDTH       = 11,
  parameter int MAX_DEL     = 16,
  parameter int DEFAULT_DEL = 4,
  parameter int DEL_W       = $clog2(MAX_DEL + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [DEL_W-1:0] del_sel,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic [WIDTH-1:0] dout,
  output logic             dout_valid,
  output logic [DEL_W-1:0] del_cur,
  output logic             busy
);

  localparam int               c_DEF_INT = (DEFAULT_DEL < 1)       ? 1       :
                                           (DEFAULT_DEL > MAX_DEL) ? MAX_DEL : DEFAULT_DEL;
  localparam logic [DEL_W-1:0] c_DEF_DEL = DEL_W'(c_DEF_INT);
  localparam logic [DEL_W-1:0] c_MAX_DEL = DEL_W'(MAX_DEL);
  localparam logic [DEL_W-1:0] c_ONE     = DEL_W'(1);

  logic [WIDTH-1:0]   r_data [MAX_DEL];
  logic [MAX_DEL-1:0] r_vld;
  logic [DEL_W-1:0]   r_del_cur;
  logic [DEL_W-1:0]   r_fill;

  logic [DEL_W-1:0]   w_eff_sel;
  logic               w_change;
  logic               w_busy;
  logic               w_tap_vld;
  logic [WIDTH-1:0]   w_tap_data;

  always_comb begin
    w_eff_sel = del_sel;
    if (del_sel == '0) begin
      w_eff_sel = c_ONE;
    end else if (del_sel > c_MAX_DEL) begin
      w_eff_sel = c_MAX_DEL;
    end
  end

  assign w_change = (w_eff_sel != r_del_cur);
  assign w_busy   = (r_fill < r_del_cur);

  // Fill counter counts post-change captures; it saturates at the active delay.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_del_cur <= c_DEF_DEL;
      r_fill    <= '0;
    end else if (w_change) begin
      r_del_cur <= w_eff_sel;
      r_fill    <= en ? c_ONE : '0;
    end else if (en && w_busy) begin
      r_fill    <= r_fill + c_ONE;
    end
  end

  // Stale data bits survive a flush; only the valid bits are cleared.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld <= '0;
      for (int i = 0; i < MAX_DEL; i++) begin
        r_data[i] <= '0;
      end
    end else begin
      if (en) begin
        r_vld[0]  <= din_valid;
        r_data[0] <= din;
      end else if (w_change) begin
        r_vld[0]  <= 1'b0;
      end
      for (int i = 1; i < MAX_DEL; i++) begin
        if (en) begin
          r_data[i] <= r_data[i-1];
        end
        if (w_change) begin
          r_vld[i] <= 1'b0;
        end else if (en) begin
          r_vld[i] <= r_vld[i-1];
        end
      end
    end
  end

  always_comb begin
    w_tap_vld  = 1'b0;
    w_tap_data = '0;
    for (int i = 0; i < MAX_DEL; i++) begin
      if (r_del_cur == DEL_W'(i + 1)) begin
        w_tap_vld  = r_vld[i];
        w_tap_data = r_data[i];
      end
    end
  end

  assign dout       = w_tap_vld ? w_tap_data : '0;
  assign dout_valid = w_tap_vld;
  assign del_cur    = r_del_cur;
  assign busy       = w_busy;

endmodule
`default_nettype wire

// File: tb/tb_delay_prog.sv
`default_nettype none
// ============================================================================
// Module   : tb_delay_prog
// Brief    : Directed and randomized checks of delay_prog against a capture-
//            history model (sample index N-del valid only if after last flush).
// Revision : 1.0 - initial release
// ============================================================================
module tb_delay_prog;

  localparam int WIDTH   = 11;
  localparam int MAX_DEL = 16;
  localparam int DEL_W   = 5;

  logic             clk;
  logic             rst_n;
  logic             en;
  logic [DEL_W-1:0] del_sel;
  logic [WIDTH-1:0] din;
  logic             din_valid;
  logic [WIDTH-1:0] dout;
  logic             dout_valid;
  logic [DEL_W-1:0] del_cur;
  logic             busy;

  int total = 0;
  int bad   = 0;

  delay_prog #(
    .WIDTH      (WIDTH),
    .MAX_DEL    (MAX_DEL),
    .DEFAULT_DEL(4),
    .DEL_W      (DEL_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .del_sel   (del_sel),
    .din       (din),
    .din_valid (din_valid),
    .dout      (dout),
    .dout_valid(dout_valid),
    .del_cur   (del_cur),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: every enabled edge captures sample number m_n; a delay change
  // records m_flush so that captures older than the change never emerge.
  int               m_n;
  int               m_flush;
  int               m_del;
  logic [WIDTH:0]   ring [32];

  function automatic int clamp(input int s);
    if (s == 0) return 1;
    if (s > MAX_DEL) return MAX_DEL;
    return s;
  endfunction

  initial begin
    m_n = 0; m_flush = 0; m_del = 4;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m_n = 0; m_flush = 0; m_del = 4;
      end else begin
        if (clamp(int'(del_sel)) != m_del) begin
          m_del   = clamp(int'(del_sel));
          m_flush = m_n;
        end
        if (en) begin
          ring[m_n % 32] = {din_valid, din};
          m_n++;
        end
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  // Compare process: DUT outputs against the model on every falling edge.
  initial begin
    forever begin
      @(negedge clk);
      begin
        int             idx;
        logic           ev;
        logic [WIDTH:0] ent;
        idx = m_n - m_del;
        ev  = 1'b0;
        ent = '0;
        if (idx >= m_flush && idx >= 0) begin
          ent = ring[idx % 32];
          ev  = ent[WIDTH];
        end
        chk("model_valid", int'(dout_valid), int'(ev));
        chk("model_dout", int'(dout), ev ? int'(ent[WIDTH-1:0]) : 0);
        chk("model_delcur", int'(del_cur), m_del);
        chk("model_busy", int'(busy), int'((m_n - m_flush) < m_del));
      end
    end
  end

  task automatic drive(input logic e, input int s, input logic v, input int d);
    en        = e;
    del_sel   = DEL_W'(s);
    din_valid = v;
    din       = WIDTH'(d);
    #3;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic scen_reset_stream();
    for (int k = 0; k < 10; k++) begin
      drive(1'b1, 4, 1'b1, k);
      chk("rst_valid", int'(dout_valid), int'(k >= 4));
      chk("rst_dout", int'(dout), (k >= 4) ? k - 4 : 0);
      chk("rst_busy", int'(busy), int'(k < 4));
      next_cycle();
    end
  endtask

  task automatic random_phase(input int n);
    int sel;
    sel = int'(del_sel);
    for (int c = 0; c < n; c++) begin
      if ($urandom_range(0, 15) == 0) sel = int'($urandom_range(0, 31));
      drive($urandom_range(0, 7) != 0, sel, $urandom_range(0, 3) != 0,
            int'($urandom_range(0, 2047)));
      next_cycle();
    end
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b1; del_sel = 5'd4; din = '0; din_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_valid", int'(dout_valid), 0);
    chk("reset_delcur", int'(del_cur), 4);
    chk("reset_busy", int'(busy), 1);
    rst_n = 1'b1;
    scen_reset_stream();

    // Delay change 4 -> 2 in cycle 20.
    for (int k = 10; k < 23; k++) begin
      drive(1'b1, (k >= 20) ? 2 : 4, 1'b1, k);
      if (k == 19) chk("chg_c19_dout", int'(dout), 15);
      if (k == 20) begin
        chk("chg_c20_dout", int'(dout), 16);
        chk("chg_c20_busy", int'(busy), 0);
      end
      if (k == 21) begin
        chk("chg_c21_valid", int'(dout_valid), 0);
        chk("chg_c21_busy", int'(busy), 1);
        chk("chg_c21_delcur", int'(del_cur), 2);
      end
      if (k == 22) begin
        chk("chg_c22_dout", int'(dout), 20);
        chk("chg_c22_busy", int'(busy), 0);
      end
      next_cycle();
    end

    // Three stall cycles at delay 2.
    for (int k = 23; k < 28; k++) begin
      drive(!(k >= 23 && k <= 25), 2, 1'b1, k);
      if (k == 24) begin
        chk("stall_valid", int'(dout_valid), 1);
        chk("stall_dout", int'(dout), 21);
      end
      if (k == 27) chk("stall_after_dout", int'(dout), 22);
      next_cycle();
    end

    // Valid gaps 1,0,1,1,0 in cycles 30..34 at delay 3.
    for (int k = 28; k < 38; k++) begin
      drive(1'b1, 3, !(k == 31 || k == 34), k);
      if (k == 34) begin
        chk("gap_valid", int'(dout_valid), 0);
        chk("gap_dout", int'(dout), 0);
      end
      if (k == 35) chk("gap_dout_after", int'(dout), 32);
      next_cycle();
    end

    // Clamp low and high.
    for (int k = 38; k < 57; k++) begin
      drive(1'b1, (k < 40) ? 0 : 31, 1'b1, k);
      if (k == 39) begin
        chk("clamp0_delcur", int'(del_cur), 1);
        chk("clamp0_dout", int'(dout), 38);
      end
      if (k == 41) chk("clamp31_delcur", int'(del_cur), 16);
      if (k == 55) chk("clamp31_c55_valid", int'(dout_valid), 0);
      if (k == 56) chk("clamp31_c56_dout", int'(dout), 40);
      next_cycle();
    end

    random_phase(600);

    // Async reset between edges while the line is emitting.
    for (int c = 0; c < 5; c++) begin
      drive(1'b1, 2, 1'b1, 100 + c);
      next_cycle();
    end
    chk("pre_areset_valid", int'(dout_valid), 1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("areset_valid", int'(dout_valid), 0);
    chk("areset_dout", int'(dout), 0);
    chk("areset_busy", int'(busy), 1);
    chk("areset_delcur", int'(del_cur), 4);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    scen_reset_stream();

    random_phase(400);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
